// File: rtl/render_pkg.sv
// Shared definitions for the render host.
// Holds the camera configuration word count, the indices of the image
// dimension words inside the configuration block and the FSM state encoding.
package render_pkg;

    localparam int unsigned CAMERA_WORDS     = 27;
    localparam int unsigned CFG_ADDR_W       = 5;
    localparam int unsigned IMAGE_WIDTH_IDX  = 1;
    localparam int unsigned IMAGE_HEIGHT_IDX = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSendCfg,
        StRecvFrag,
        StFinish
    } state_t;

endpackage

// File: rtl/dp_ram_dist_flat.sv
// Distributed (LUT) dual-port RAM: one synchronous write port, one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk           write clock
//   we/waddr/wdata  write port; addresses >= DEPTH are ignored
//   raddr/rdata   combinational read port; addresses >= DEPTH read as zero
module dp_ram_dist_flat #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 27,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/render_host.sv
// Render host: streams the camera configuration block to a coprocessor over
// AXIS, then collects the returned fragments into a framebuffer.
// Ports:
//   aclk, resetn                     clock, async active-low reset
//   cfg_we/cfg_addr/cfg_wdata        configuration store write (IDLE only)
//   start                            request one frame
//   busy, done, err_len              status; done is a one-cycle pulse
//   m_axis_*                         configuration words out
//   s_axis_*                         fragments in
//   fb_we/fb_addr/fb_wdata           framebuffer write port
//   frag_count                       fragments accepted in current/last frame
module render_host #(
    parameter int unsigned CAMERA_WORDS = render_pkg::CAMERA_WORDS,
    parameter int unsigned FB_ADDR_W    = 20
) (
    input  logic                 aclk,
    input  logic                 resetn,
    input  logic                 cfg_we,
    input  logic [4:0]           cfg_addr,
    input  logic [31:0]          cfg_wdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic                 m_axis_tvalid,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    input  logic                 s_axis_tvalid,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [31:0]          fb_wdata,
    output logic [31:0]          frag_count
);
    import render_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(CAMERA_WORDS - 1);

    state_t               state_q, state_d;
    logic [4:0]           idx_q;
    logic                 m_valid_q, m_last_q, s_ready_q;
    logic [31:0]          m_data_q;
    logic                 fb_we_q;
    logic [FB_ADDR_W-1:0] fb_addr_q;
    logic [31:0]          fb_wdata_q;
    logic [31:0]          count_q, expected_q;
    logic                 err_q;
    logic [15:0]          width_q, height_q;

    logic        cfg_wr;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        m_hs, s_hs;

    assign cfg_wr = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < CAMERA_WORDS);
    assign m_hs   = m_valid_q && m_axis_tready;
    assign s_hs   = s_axis_tvalid && s_ready_q;
    // Read port looks one word ahead so the next beat is registered with no bubble.
    assign raddr  = (state_q == StIdle) ? 5'd0 : idx_q + 5'd1;

    dp_ram_dist_flat #(
        .WIDTH  (32),
        .DEPTH  (CAMERA_WORDS),
        .ADDR_W (5)
    ) u_cfg_ram (
        .clk   (aclk),
        .we    (cfg_wr),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Shadow copies of the image dimensions so the expected fragment count can
    // be formed on the start cycle without a second RAM read port.
    always_ff @(posedge aclk) begin
        if (cfg_wr && (cfg_addr == 5'(IMAGE_WIDTH_IDX))) begin
            width_q <= cfg_wdata[15:0];
        end
        if (cfg_wr && (cfg_addr == 5'(IMAGE_HEIGHT_IDX))) begin
            height_q <= cfg_wdata[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StSendCfg;
            StSendCfg:  if (m_hs && m_last_q) state_d = StRecvFrag;
            StRecvFrag: if (s_hs && s_axis_tlast) state_d = StFinish;
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            s_ready_q  <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            count_q    <= '0;
            expected_q <= '0;
            err_q      <= 1'b0;
        end else begin
            fb_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q      <= '0;
                        m_valid_q  <= 1'b1;
                        m_data_q   <= rdata;
                        m_last_q   <= (LAST_IDX == 5'd0);
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        expected_q <= 32'(width_q) * 32'(height_q);
                    end
                end
                StSendCfg: begin
                    if (m_hs) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            s_ready_q <= 1'b1;
                        end else begin
                            idx_q    <= idx_q + 5'd1;
                            m_data_q <= rdata;
                            m_last_q <= ((idx_q + 5'd1) == LAST_IDX);
                        end
                    end
                end
                StRecvFrag: begin
                    if (s_hs) begin
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_q <= count_q + 32'd1;
                        end
                        // Fragments beyond the expected count are consumed and dropped.
                        if (count_q < expected_q) begin
                            fb_we_q    <= 1'b1;
                            fb_addr_q  <= count_q[FB_ADDR_W-1:0];
                            fb_wdata_q <= s_axis_tdata;
                        end
                        if (s_axis_tlast) begin
                            s_ready_q <= 1'b0;
                            err_q     <= ({1'b0, count_q} + 33'd1) != {1'b0, expected_q};
                        end
                    end
                end
                StFinish: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StFinish);
    assign err_len       = err_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign s_axis_tready = s_ready_q;
    assign fb_we         = fb_we_q;
    assign fb_addr       = fb_addr_q;
    assign fb_wdata      = fb_wdata_q;
    assign frag_count    = count_q;

endmodule

// File: tb/tb_render_host.sv
// Directed self-checking bench for render_host.
module tb_render_host;

    localparam int CW  = 27;
    localparam int FBW = 20;

    logic            aclk;
    logic            resetn;
    logic            cfg_we;
    logic [4:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic            start;
    logic            busy, done, err_len;
    logic            m_axis_tvalid, m_axis_tlast;
    logic [31:0]     m_axis_tdata;
    logic            m_axis_tready = 1'b1;
    logic            s_axis_tvalid, s_axis_tlast;
    logic [31:0]     s_axis_tdata;
    logic            s_axis_tready;
    logic            fb_we;
    logic [FBW-1:0]  fb_addr;
    logic [31:0]     fb_wdata;
    logic [31:0]     frag_count;

    render_host #(
        .CAMERA_WORDS (CW),
        .FB_ADDR_W    (FBW)
    ) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_wdata      (fb_wdata),
        .frag_count    (frag_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Sink ready: constant high, or toggling every cycle when toggle is set.
    logic toggle = 1'b0;
    always @(posedge aclk) begin
        #1;
        m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
    end

    // Bus monitor, sampled mid-cycle.
    logic [31:0] beat_d [$];
    logic        beat_l [$];
    int          beat_c [$];
    logic [31:0] fb_a [$];
    logic [31:0] fb_d [$];
    int          done_cnt = 0;
    int          cyc = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [31:0] prev_d = '0;

    always @(negedge aclk) begin
        cyc++;
        if (prev_v && !prev_r) begin
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata", m_axis_tdata, prev_d);
            check("stall_tlast", 32'(m_axis_tlast), 32'(prev_l));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_d.push_back(m_axis_tdata);
            beat_l.push_back(m_axis_tlast);
            beat_c.push_back(cyc);
        end
        if (fb_we) begin
            fb_a.push_back(32'(fb_addr));
            fb_d.push_back(fb_wdata);
        end
        if (done) done_cnt++;
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
    end

    logic [31:0] cfg_m [CW];

    task automatic clear_mon();
        beat_d.delete();
        beat_l.delete();
        beat_c.delete();
        fb_a.delete();
        fb_d.delete();
        done_cnt = 0;
    endtask

    // All stimulus tasks start and end at posedge + 1.
    task automatic write_cfg(input int a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(a);
        cfg_wdata = d;
        @(posedge aclk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_sready();
        int n = 0;
        while (!s_axis_tready && n < 400) begin
            @(posedge aclk); #1;
            n++;
        end
        if (!s_axis_tready) check("timeout_sready", 32'd0, 32'd1);
    endtask

    task automatic send_frags(input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hA0 + 32'(i);
            s_axis_tlast  = with_last && (i == n - 1);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(posedge aclk); #1;
            n++;
        end
        if (busy) check("timeout_idle", 32'd1, 32'd0);
        @(posedge aclk); #1;
    endtask

    task automatic check_beats(input logic back_to_back);
        check("beat_count", 32'(beat_d.size()), 32'(CW));
        for (int i = 0; i < beat_d.size() && i < CW; i++) begin
            check($sformatf("beat_data[%0d]", i), beat_d[i], cfg_m[i]);
            check($sformatf("beat_last[%0d]", i), 32'(beat_l[i]), 32'(i == CW - 1));
        end
        if (back_to_back && beat_c.size() == CW)
            check("beat_span", 32'(beat_c[CW-1] - beat_c[0]), 32'(CW - 1));
    endtask

    task automatic check_fb(input int n);
        check("fb_writes", 32'(fb_a.size()), 32'(n));
        for (int i = 0; i < fb_a.size() && i < n; i++) begin
            check($sformatf("fb_addr[%0d]", i), fb_a[i], 32'(i));
            check($sformatf("fb_data[%0d]", i), fb_d[i], 32'hA0 + 32'(i));
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_done"}, 32'(done), 32'd0);
        check({p, "_err"}, 32'(err_len), 32'd0);
        check({p, "_mvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({p, "_mlast"}, 32'(m_axis_tlast), 32'd0);
        check({p, "_mdata"}, m_axis_tdata, 32'd0);
        check({p, "_sready"}, 32'(s_axis_tready), 32'd0);
        check({p, "_fbwe"}, 32'(fb_we), 32'd0);
        check({p, "_fbaddr"}, 32'(fb_addr), 32'd0);
        check({p, "_count"}, frag_count, 32'd0);
    endtask

    task automatic check_end(input string p, input int cnt, input logic err);
        check({p, "_count"}, frag_count, 32'(cnt));
        check({p, "_err"}, 32'(err_len), 32'(err));
        check({p, "_done"}, 32'(done_cnt), 32'd1);
        check({p, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_wdata     = '0;
        start         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_vals("por");
        resetn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < CW; i++) begin
            cfg_m[i] = (i == 1) ? 32'd4 : (i == 2) ? 32'd2 : 32'h100 + 32'(i);
            write_cfg(i, cfg_m[i]);
        end

        // Nominal frame: 8 fragments, expected 4*2.
        clear_mon();
        pulse_start();
        wait_sready();
        check_beats(1'b1);
        send_frags(8, 1'b1);
        wait_idle();
        check_fb(8);
        check_end("nominal", 8, 1'b0);

        // Stalling sink; start and cfg_we during reception must be ignored.
        toggle = 1'b1;
        clear_mon();
        pulse_start();
        wait_sready();
        check_beats(1'b0);
        start     = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 5'd0;
        cfg_wdata = 32'hDEADBEEF;
        @(posedge aclk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        check("recv_sready_held", 32'(s_axis_tready), 32'd1);
        send_frags(8, 1'b1);
        wait_idle();
        check_fb(8);
        check_end("stall", 8, 1'b0);
        toggle = 1'b0;
        @(posedge aclk); #1;

        // Too many fragments.
        clear_mon();
        pulse_start();
        wait_sready();
        send_frags(10, 1'b1);
        wait_idle();
        check_fb(8);
        check_end("long", 10, 1'b1);

        // Too few fragments.
        clear_mon();
        pulse_start();
        wait_sready();
        send_frags(5, 1'b1);
        wait_idle();
        check_fb(5);
        check_end("short", 5, 1'b1);

        // Reset mid-frame after the 3rd fragment.
        clear_mon();
        pulse_start();
        wait_sready();
        send_frags(3, 1'b0);
        resetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge aclk); #1;
        resetn = 1'b1;
        @(posedge aclk); #1;
        clear_mon();
        pulse_start();
        wait_sready();
        check_beats(1'b1);
        send_frags(8, 1'b1);
        wait_idle();
        check_fb(8);
        check_end("after_rst", 8, 1'b0);

        // Expected count of zero: everything dropped, length error flagged.
        cfg_m[1] = 32'd0;
        write_cfg(1, 32'd0);
        clear_mon();
        pulse_start();
        wait_sready();
        check_beats(1'b1);
        send_frags(3, 1'b1);
        wait_idle();
        check_fb(0);
        check_end("zero", 3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/render_host.md
RENDER_HOST -- requirements
Module: render_host

Interface
REQ-001 Parameter CAMERA_WORDS, default 27, number of camera configuration words sent per frame.
REQ-002 Parameter FB_ADDR_W, default 20, framebuffer address width.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 cfg_we / cfg_addr / cfg_wdata  input  1 / 5 / 32  host write port into the camera configuration store.
REQ-006 start  input  1  one-cycle request to render one frame.
REQ-007 busy / done / err_len  output  1 / 1 / 1  frame in progress; one-cycle completion pulse; fragment-count mismatch flag.
REQ-008 m_axis_tvalid / m_axis_tdata / m_axis_tlast / m_axis_tready  out / out / out / in  1 / 32 / 1 / 1  AXIS master carrying configuration words to the coprocessor.
REQ-009 s_axis_tvalid / s_axis_tdata / s_axis_tlast / s_axis_tready  in / in / in / out  1 / 32 / 1 / 1  AXIS slave accepting fragments from the coprocessor.
REQ-010 fb_we / fb_addr / fb_wdata  output  1 / FB_ADDR_W / 32  framebuffer write port.
REQ-011 frag_count  output  32  fragments accepted in the current or last frame.

Function
REQ-012 States: IDLE, SEND_CFG, RECV_FRAG, FINISH; busy is high in every state except IDLE.
REQ-013 IDLE: cfg_we writes cfg_wdata to word cfg_addr (addresses >= CAMERA_WORDS ignored); cfg_we outside IDLE is ignored.
REQ-014 IDLE + start: latch expected = cfg[1][15:0] * cfg[2][15:0] (unsigned, 32-bit result); clear frag_count and err_len; go to SEND_CFG; start in any other state is ignored.
REQ-015 SEND_CFG: m_axis_tvalid asserted the cycle after entry with tdata = cfg[0]; each beat with tvalid && tready advances to the next word, registered, with no bubble.
REQ-016 m_axis_tdata and m_axis_tlast stay stable and m_axis_tvalid never deasserts while tvalid is high and tready is low.
REQ-017 m_axis_tlast is high only on word CAMERA_WORDS-1; its handshake deasserts tvalid and moves to RECV_FRAG.
REQ-018 RECV_FRAG: s_axis_tready held high; each beat with tvalid && tready increments frag_count (saturating at 2^32-1).
REQ-019 For each accepted beat with pre-increment count < expected: one cycle later fb_we=1, fb_addr=count[FB_ADDR_W-1:0], fb_wdata=tdata.
REQ-020 Beats with count >= expected are consumed but not written to the framebuffer.
REQ-021 A beat with tlast ends reception: s_axis_tready drops the next cycle; err_len = (count+1 != expected); go to FINISH.
REQ-022 FINISH: done=1 for exactly one cycle, then IDLE; err_len and frag_count hold until the next accepted start.
REQ-023 expected = 0: still sends the configuration; every received beat is dropped; err_len is set at tlast.

Reset
REQ-024 resetn low, at any time including mid-frame: state IDLE; m_axis_tvalid, m_axis_tlast, s_axis_tready, fb_we, busy, done and err_len are 0; frag_count and the word index are 0; m_axis_tdata and fb_addr are 0.
REQ-025 Configuration store contents are not reset; after reset release, the first start sends the previously written values.

Structure
REQ-026 Shared package render_pkg holds CAMERA_WORDS, IMAGE_WIDTH_IDX=1, IMAGE_HEIGHT_IDX=2 and the state encoding.
REQ-027 Configuration storage instantiates the existing dp_ram_dist_flat (WIDTH 32, DEPTH CAMERA_WORDS); no other sub-module.

Verification
REQ-028 cfg[i]=0x100+i with cfg[1]=4 and cfg[2]=2, start, tready always 1 -> 27 back-to-back beats 0x100..0x11A, tlast on the 27th only.
REQ-029 Same configuration, with m_axis_tready toggling 1-0 each cycle -> tdata and tvalid stable across stalls; all 27 words delivered in order.
REQ-030 8 fragments 0xA0..0xA7, tlast on the 8th -> fb writes at addresses 0..7 with the matching data, frag_count=8, err_len=0, one done pulse.
REQ-031 10 fragments with expected 8 -> only addresses 0..7 written, frag_count=10, err_len=1; 5 fragments with tlast on the 5th -> err_len=1.
REQ-032 resetn pulsed low after the 3rd fragment -> all outputs return to reset values; a new start resends the original configuration.
REQ-033 start and cfg_we asserted during RECV_FRAG -> no effect on the frame or on the configuration store.
